// File: rtl/dp_ram_fifo_ctrl.sv
// dp_ram_fifo_ctrl: valid/ready circular-buffer FIFO controller driving an external dual-port RAM
// (async read port, sync write port); pointers carry an extra wrap bit to tell full from empty.
module dp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BASE_ADDR = 0,
  parameter int AF_THRESH = 6,
  localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  localparam int RAM_AW = ADDR_WIDTH + $clog2(BASE_ADDR + 1) + 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_flush,
  input  logic                  i_push_valid,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  output logic                  o_push_ready,
  output logic                  o_pop_valid,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  input  logic                  i_pop_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  ram_wr_en,
  output logic [RAM_AW-1:0]     ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_rd_en,
  output logic [RAM_AW-1:0]     ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  localparam logic [ADDR_WIDTH:0] AF_C = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [RAM_AW-1:0] BASE_C = RAM_AW'(BASE_ADDR);
  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic push_fire, pop_fire;
  assign o_empty = wr_ptr_q == rd_ptr_q;
  assign o_full = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                  (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign o_almost_full = count_q >= AF_C;
  assign o_count = count_q;
  assign o_push_ready = !o_full;
  assign o_pop_valid = !o_empty;
  assign ram_rd_en = !o_empty;
  assign push_fire = i_push_valid & o_push_ready;
  assign pop_fire = o_pop_valid & i_pop_ready;
  // write strobe is qualified so the RAM never captures during reset or flush
  assign ram_wr_en = push_fire & n_rst & !i_flush;
  assign ram_wr_addr = BASE_C + RAM_AW'(wr_ptr_q[ADDR_WIDTH-1:0]);
  assign ram_rd_addr = BASE_C + RAM_AW'(rd_ptr_q[ADDR_WIDTH-1:0]);
  assign ram_data_in = i_push_data;
  assign o_pop_data = o_empty ? '0 : ram_data_out;
  always_comb begin
    wr_ptr_d = i_flush ? '0 : wr_ptr_q + (ADDR_WIDTH + 1)'(push_fire);
    rd_ptr_d = i_flush ? '0 : rd_ptr_q + (ADDR_WIDTH + 1)'(pop_fire);
    count_d = i_flush ? '0 : count_q + (ADDR_WIDTH + 1)'(push_fire) - (ADDR_WIDTH + 1)'(pop_fire);
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// tb_dp_ram_fifo_ctrl: directed vector bench for dp_ram_fifo_ctrl (DEPTH=8, BASE=0, AF=6)
// with a behavioural dual-port RAM attached to the ram_* ports.
module tb_dp_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic n_rst, i_flush, i_push_valid, i_pop_ready;
  logic [7:0] i_push_data, o_pop_data, ram_data_in, ram_data_out;
  logic o_push_ready, o_pop_valid, o_full, o_empty, o_almost_full, ram_wr_en, ram_rd_en;
  logic [3:0] o_count, ram_wr_addr, ram_rd_addr;
  logic [7:0] mem [0:15];
  int errors = 0, checks = 0;

  typedef struct {
    int rn, fl, pv, pd, pr, cnt, we, wa, pvld, pdat;
  } vec_t;
  vec_t tbl [19];

  always #5 clk = ~clk;

  dp_ram_fifo_ctrl dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
    .i_push_valid(i_push_valid), .i_push_data(i_push_data), .o_push_ready(o_push_ready),
    .o_pop_valid(o_pop_valid), .o_pop_data(o_pop_data), .i_pop_ready(i_pop_ready),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_almost_full(o_almost_full),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
  );

  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
  assign ram_data_out = mem[ram_rd_addr];

  function automatic vec_t mk(int rn, int fl, int pv, int pd, int pr,
                              int cnt, int we, int wa, int pvld, int pdat);
    mk = '{rn, fl, pv, pd, pr, cnt, we, wa, pvld, pdat};
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // drive at negedge, sample 1ns later, then advance through the next posedge
  task automatic apply(vec_t v);
    n_rst = v.rn[0];
    i_flush = v.fl[0];
    i_push_valid = v.pv[0];
    i_push_data = 8'(v.pd);
    i_pop_ready = v.pr[0];
    #1;
    chk("count", int'(o_count), v.cnt);
    chk("empty", int'(o_empty), int'(v.cnt == 0));
    chk("full", int'(o_full), int'(v.cnt == 8));
    chk("almost_full", int'(o_almost_full), int'(v.cnt >= 6));
    chk("push_ready", int'(o_push_ready), int'(v.cnt != 8));
    chk("pop_valid", int'(o_pop_valid), v.pvld);
    chk("rd_en", int'(ram_rd_en), v.pvld);
    chk("pop_data", int'(o_pop_data), v.pdat);
    chk("wr_en", int'(ram_wr_en), v.we);
    if (v.rn != 0) chk("wr_addr", int'(ram_wr_addr), v.wa);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    n_rst = 1'b0; i_flush = 1'b0; i_push_valid = 1'b1; i_push_data = 8'hFF; i_pop_ready = 1'b0;
    @(negedge clk);
    #1 chk("reset_wr_en", int'(ram_wr_en), 0);
    @(negedge clk);
    // reset, fill to full (9th push refused), drain in order
    tbl[0] = mk(0, 0, 1, 'hFF, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      tbl[k] = mk(1, 0, 1, 'h11 * k, 0, k - 1, 1, k - 1, int'(k > 1), (k > 1) ? 'h11 : 0);
    tbl[9] = mk(1, 0, 1, 'h99, 0, 8, 0, 0, 1, 'h11);
    for (int j = 0; j < 8; j++)
      tbl[10 + j] = mk(1, 0, 0, 0, 1, 8 - j, 0, 0, 1, 'h11 * (j + 1));
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // wrap: push 5, pop 5, push 8 across the index wrap
    for (int k = 0; k < 5; k++) apply(mk(1, 0, 1, 'hC0 + k, 0, k, 1, k, int'(k > 0), (k > 0) ? 'hC0 : 0));
    for (int j = 0; j < 5; j++) apply(mk(1, 0, 0, 0, 1, 5 - j, 0, 5, 1, 'hC0 + j));
    for (int k = 0; k < 8; k++)
      apply(mk(1, 0, 1, 'hA0 + k, 0, k, 1, (5 + k) % 8, int'(k > 0), (k > 0) ? 'hA0 : 0));

    // full with push+pop: only the pop happens
    apply(mk(1, 0, 1, 'hEE, 1, 8, 0, 5, 1, 'hA0));
    for (int j = 0; j < 4; j++) apply(mk(1, 0, 0, 0, 1, 7 - j, 0, 5, 1, 'hA1 + j));
    // count 3, simultaneous push+pop for 10 cycles
    for (int k = 0; k < 10; k++)
      apply(mk(1, 0, 1, 'hB0 + k, 1, 3, 1, (5 + k) % 8, 1, (k < 3) ? 'hA5 + k : 'hB0 + k - 3));
    for (int j = 0; j < 3; j++) apply(mk(1, 0, 0, 0, 1, 3 - j, 0, 7, 1, 'hB7 + j));

    // empty: push+pop same cycle, pop is ignored, entry visible next cycle
    apply(mk(1, 0, 1, 'h5A, 1, 0, 1, 7, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 'h5A));
    apply(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 'h5A));

    // flush at count 5 with push pending: no write, pointers back to zero
    for (int k = 0; k < 5; k++) apply(mk(1, 0, 1, 'hD0 + k, 0, k, 1, k, int'(k > 0), (k > 0) ? 'hD0 : 0));
    apply(mk(1, 1, 1, 'hEE, 1, 5, 0, 5, 1, 'hD0));
    apply(mk(1, 0, 1, 'h77, 0, 0, 1, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 1, 0, 1, 1, 'h77));

    // mid-stream reset drops contents
    apply(mk(0, 0, 1, 'h33, 0, 1, 0, 0, 1, 'h77));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
